// File: rtl/capture_sequencer.sv
// capture_sequencer: acquisition controller for the scope datapath.
// Sequences waveform-RAM writes from the ADC sample stream: pre-trigger fill,
// rising-edge level trigger with hysteresis (plus auto-mode timeout), post-trigger
// fill, and a frame-ready handshake with the display reader.
// Ports:
//   clk100, reset          clock, asynchronous active-high reset
//   sample_valid/data      one-cycle sample strobe and unsigned sample
//   trig_level/hyst        trigger threshold and hysteresis below it
//   mode                   00 auto, 01 normal, 10 single, 11 stop
//   arm                    re-arm pulse (honoured in STOPPED only)
//   frame_done             display finished reading (honoured in DISPLAY only)
//   wr_en/addr/data        registered RAM write port
//   start_addr             display start = trigger address - PRE_DEPTH (mod depth)
//   frame_ready            RAM holds a complete triggered frame
//   auto_trig              last frame was force-triggered by timeout
//   state_o                current state encoding
module capture_sequencer #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned PRE_DEPTH    = 512,
    parameter int unsigned AUTO_TIMEOUT = 2000000
) (
    input  logic              clk100,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] trig_level,
    input  logic [3:0]        trig_hyst,
    input  logic [1:0]        mode,
    input  logic              arm,
    input  logic              frame_done,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] start_addr,
    output logic              frame_ready,
    output logic              auto_trig,
    output logic [2:0]        state_o
);

    localparam int unsigned DEPTH       = 1 << ADDR_W;
    localparam int unsigned POST_WRITES = DEPTH - PRE_DEPTH - 1;
    localparam int unsigned TO_W        = $clog2(AUTO_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PREFILL = 3'd1,
        ARMED   = 3'd2,
        POST    = 3'd3,
        DISPLAY = 3'd4,
        STOPPED = 3'd5
    } state_t;

    state_t              state;
    logic [ADDR_W-1:0]   ptr;
    logic [ADDR_W-1:0]   cnt;
    logic [TO_W-1:0]     to_cnt;
    logic                below;

    logic [DATA_W-1:0]   thresh_c;
    logic                capturing_c;
    logic                abort_c;
    logic                write_c;
    logic                real_trig_c;
    logic                timeout_c;

    assign state_o = state;

    // Hysteresis threshold saturates at zero; trigger/abort/write qualifiers.
    always_comb begin
        thresh_c = '0;
        if (trig_level >= DATA_W'(trig_hyst)) begin
            thresh_c = trig_level - DATA_W'(trig_hyst);
        end
        capturing_c = (state == PREFILL) || (state == ARMED) || (state == POST);
        abort_c     = capturing_c && (mode == 2'b11);
        write_c     = capturing_c && sample_valid && !abort_c;
        // The below-flag is the one set by earlier samples: the edge must come from below.
        real_trig_c = below && (sample_data >= trig_level);
        timeout_c   = (mode == 2'b00) && (to_cnt == TO_W'(AUTO_TIMEOUT - 1));
    end

    // Sequencer state, write port and status registers.
    always_ff @(posedge clk100 or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= '0;
            cnt         <= '0;
            to_cnt      <= '0;
            below       <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            start_addr  <= '0;
            frame_ready <= 1'b0;
            auto_trig   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (write_c) begin
                wr_en   <= 1'b1;
                wr_addr <= ptr;
                wr_data <= sample_data;
                ptr     <= ptr + ADDR_W'(1);
            end

            case (state)
                IDLE: begin
                    if (mode == 2'b11) begin
                        state <= STOPPED;
                    end else begin
                        state       <= PREFILL;
                        cnt         <= '0;
                        below       <= 1'b0;
                        frame_ready <= 1'b0;
                    end
                end

                PREFILL: begin
                    if (abort_c) begin
                        state <= STOPPED;
                    end else if (write_c) begin
                        if (cnt == ADDR_W'(PRE_DEPTH - 1)) begin
                            state  <= ARMED;
                            cnt    <= '0;
                            to_cnt <= '0;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end

                ARMED: begin
                    if (abort_c) begin
                        state <= STOPPED;
                    end else if (write_c) begin
                        if (real_trig_c || timeout_c) begin
                            state      <= POST;
                            start_addr <= ptr - ADDR_W'(PRE_DEPTH);
                            auto_trig  <= !real_trig_c;
                            cnt        <= '0;
                        end else begin
                            if (sample_data <= thresh_c) begin
                                below <= 1'b1;
                            end
                            if (mode == 2'b00) begin
                                to_cnt <= to_cnt + TO_W'(1);
                            end
                        end
                    end
                end

                POST: begin
                    if (abort_c) begin
                        state <= STOPPED;
                    end else if (write_c) begin
                        if (cnt == ADDR_W'(POST_WRITES - 1)) begin
                            state       <= DISPLAY;
                            frame_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + ADDR_W'(1);
                        end
                    end
                end

                DISPLAY: begin
                    if (frame_done) begin
                        if (mode[1]) begin
                            state <= STOPPED;
                        end else begin
                            state       <= PREFILL;
                            cnt         <= '0;
                            below       <= 1'b0;
                            frame_ready <= 1'b0;
                        end
                    end
                end

                STOPPED: begin
                    if (arm && (mode != 2'b11)) begin
                        state       <= PREFILL;
                        cnt         <= '0;
                        below       <= 1'b0;
                        frame_ready <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
